// File: rtl/key_event_classifier.sv
// Per-channel key gesture decoder: turns debounced key levels into
// one-cycle short / long / double press pulses.
//
// Ports:
//   clk          system clock; all state changes on its rising edge
//   rst          asynchronous reset, active low
//   key_level    [N] debounced, clk-synchronous key levels (1 = pressed)
//   short_pulse  [N] single short press completed
//   long_pulse   [N] key held for LONG_CYC samples
//   dbl_pulse    [N] double press detected
module key_event_classifier #(
    parameter int N        = 4,
    parameter int LONG_CYC = 50_000_000,
    parameter int DBL_CYC  = 12_500_000,
    parameter int CNT_W    = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key_level,
    output logic [N-1:0] short_pulse,
    output logic [N-1:0] long_pulse,
    output logic [N-1:0] dbl_pulse
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        HELD
    } state_t;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC);

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             s_q;
        logic             l_q;
        logic             d_q;
        logic             k;

        assign k = key_level[i];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state <= IDLE;
                cnt   <= '0;
                s_q   <= 1'b0;
                l_q   <= 1'b0;
                d_q   <= 1'b0;
            end else begin
                s_q <= 1'b0;
                l_q <= 1'b0;
                d_q <= 1'b0;
                unique case (state)
                    IDLE: begin
                        if (k) begin
                            state <= PRESS1;
                            cnt   <= ONE;
                        end
                    end
                    PRESS1: begin
                        if (k) begin
                            // cnt holds the highs seen before this one
                            if (cnt == LONG_LAST) begin
                                l_q   <= 1'b1;
                                state <= HELD;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + ONE;
                            end
                        end else begin
                            state <= WAIT2;
                            cnt   <= ONE;
                        end
                    end
                    WAIT2: begin
                        if (k) begin
                            state <= PRESS2;
                            cnt   <= ONE;
                        end else if (cnt == DBL_LAST) begin
                            // double window expired: commit the single press
                            s_q   <= 1'b1;
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    PRESS2: begin
                        if (!k) begin
                            d_q   <= 1'b1;
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (cnt == LONG_LAST) begin
                            // a held second press still counts as double
                            d_q   <= 1'b1;
                            state <= HELD;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end
                    HELD: begin
                        if (!k) begin
                            state <= IDLE;
                        end
                        cnt <= '0;
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign short_pulse[i] = s_q;
        assign long_pulse[i]  = l_q;
        assign dbl_pulse[i]   = d_q;
    end

endmodule
